// File: rtl/alu_dispatch_if.sv
// Command, ALU and result buses of the FP8 ALU dispatcher.
// slave = dispatcher side, master = environment side.
interface alu_dispatch_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic       alu_reset;
    logic [7:0] alu_y;
    logic       alu_valid;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_opcode;
    logic       res_error;

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_a,
        input  cmd_b,
        input  alu_y,
        input  alu_valid,
        input  res_ready,
        output cmd_ready,
        output alu_a,
        output alu_b,
        output alu_opcode,
        output alu_reset,
        output res_valid,
        output res_data,
        output res_opcode,
        output res_error
    );

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_a,
        output cmd_b,
        output alu_y,
        output alu_valid,
        output res_ready,
        input  cmd_ready,
        input  alu_a,
        input  alu_b,
        input  alu_opcode,
        input  alu_reset,
        input  res_valid,
        input  res_data,
        input  res_opcode,
        input  res_error
    );
endinterface

// File: rtl/alu_dispatch.sv
// FP8 ALU command sequencer: command FIFO, one op in flight,
// illegal-opcode rejection and completion timeout.
module alu_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    alu_dispatch_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;
    logic [3:0]    op_mem [DEPTH];
    logic [7:0]    a_mem  [DEPTH];
    logic [7:0]    b_mem  [DEPTH];
    logic          push;
    logic          pop;
    logic [3:0]    head_op;
    logic          head_legal;

    assign head_op    = op_mem[rd_ptr];
    assign head_legal = (head_op == 4'b0001) ||
                        (head_op == 4'b0010);

    // Ready looks only at count, so a pop never frees a slot the same cycle.
    assign bus.cmd_ready = reset && (count < FULL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (count != '0);

    assign bus.alu_reset = !reset || (state == ISSUE);
    assign bus.res_valid = (state == RESP);
    assign busy          = (state != IDLE) || (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            op_mem[wr_ptr] <= bus.cmd_opcode;
            a_mem[wr_ptr]  <= bus.cmd_a;
            b_mem[wr_ptr]  <= bus.cmd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            timer          <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_opcode <= '0;
            bus.res_data   <= '0;
            bus.res_opcode <= '0;
            bus.res_error  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bus.alu_a      <= a_mem[rd_ptr];
                        bus.alu_b      <= b_mem[rd_ptr];
                        bus.alu_opcode <= head_op;
                        bus.res_opcode <= head_op;
                        if (head_legal) begin
                            state <= ISSUE;
                        end else begin
                            bus.res_data  <= '0;
                            bus.res_error <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // First WAIT cycle blanks a valid left over from the last op.
                    if (bus.alu_valid && (timer != '0)) begin
                        bus.res_data  <= bus.alu_y;
                        bus.res_error <= 1'b0;
                        state         <= RESP;
                    end else if (timer == TLAST) begin
                        bus.res_data  <= '0;
                        bus.res_error <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
